// File: rtl/operand_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : RV64I OP/OP-IMM decode and register-file read feeding the ALU,
//            with a single registered output bundle and the writeback port.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rd,
    output logic            illegal
);

    localparam logic [6:0] c_OPC_OP     = 7'h33;
    localparam logic [6:0] c_OPC_OP_IMM = 7'h13;
    localparam logic [6:0] c_F7_ZERO    = 7'h00;
    localparam logic [6:0] c_F7_ALT     = 7'h20;
    localparam logic [5:0] c_SH_ARITH   = 6'h10;
    localparam logic [2:0] c_F3_ADDSUB  = 3'd0;
    localparam logic [2:0] c_F3_SLL     = 3'd1;
    localparam logic [2:0] c_F3_SR      = 3'd5;

    // ------------------------------------------------------------------
    // Register file (entry 0 exists but is never written)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_regs_q [NREGS];
    logic            w_wr_en;

    assign w_wr_en = wb_en && (wb_rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs_q[wb_rd] <= wb_data;
        end
    end

    // Same-cycle writeback is forwarded so a dependent instruction sees it.
    logic [4:0]      w_rs1_idx;
    logic [4:0]      w_rs2_idx;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    assign w_rs1_idx = instr[19:15];
    assign w_rs2_idx = instr[24:20];

    assign w_rs1_val = (w_wr_en && (wb_rd == w_rs1_idx)) ? wb_data :
                       (w_rs1_idx == 5'd0)               ? '0      :
                                                           r_regs_q[w_rs1_idx];
    assign w_rs2_val = (w_wr_en && (wb_rd == w_rs2_idx)) ? wb_data :
                       (w_rs2_idx == 5'd0)               ? '0      :
                                                           r_regs_q[w_rs2_idx];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7_raw;
    logic [5:0]      w_sh_hi;
    logic            w_dec_legal;
    logic [XLEN-1:0] w_dec_rs2;
    logic [6:0]      w_dec_f7;
    logic [XLEN-1:0] w_bnd_rs1;
    logic [XLEN-1:0] w_bnd_rs2;
    logic [2:0]      w_bnd_f3;
    logic [6:0]      w_bnd_f7;
    logic [4:0]      w_bnd_rd;
    logic            w_bnd_ill;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7_raw = instr[31:25];
    assign w_sh_hi  = instr[31:26];

    always_comb begin
        w_dec_legal = 1'b0;
        w_dec_rs2   = '0;
        w_dec_f7    = c_F7_ZERO;
        case (w_opcode)
            c_OPC_OP: begin
                w_dec_rs2   = w_rs2_val;
                w_dec_f7    = w_f7_raw;
                w_dec_legal = (w_f7_raw == c_F7_ZERO) ||
                              ((w_f7_raw == c_F7_ALT) &&
                               ((w_f3 == c_F3_ADDSUB) || (w_f3 == c_F3_SR)));
            end
            c_OPC_OP_IMM: begin
                if ((w_f3 == c_F3_SLL) || (w_f3 == c_F3_SR)) begin
                    // RV64 shifts carry a 6-bit shamt; bit 25 is not part of func7.
                    w_dec_rs2   = {{(XLEN-6){1'b0}}, instr[25:20]};
                    w_dec_f7    = {w_sh_hi, 1'b0};
                    w_dec_legal = (w_sh_hi == 6'h00) ||
                                  ((w_sh_hi == c_SH_ARITH) && (w_f3 == c_F3_SR));
                end else begin
                    w_dec_rs2   = {{(XLEN-12){instr[31]}}, instr[31:20]};
                    w_dec_f7    = c_F7_ZERO;
                    w_dec_legal = 1'b1;
                end
            end
            default: begin
                w_dec_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_bnd_rs1 = '0;
        w_bnd_rs2 = '0;
        w_bnd_f3  = '0;
        w_bnd_f7  = '0;
        w_bnd_rd  = '0;
        w_bnd_ill = 1'b1;
        if (w_dec_legal) begin
            w_bnd_rs1 = w_rs1_val;
            w_bnd_rs2 = w_dec_rs2;
            w_bnd_f3  = w_f3;
            w_bnd_f7  = w_dec_f7;
            w_bnd_rd  = instr[11:7];
            w_bnd_ill = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake and output bundle register
    // ------------------------------------------------------------------
    logic            r_valid_q;
    logic [XLEN-1:0] r_rs1_q;
    logic [XLEN-1:0] r_rs2_q;
    logic [2:0]      r_f3_q;
    logic [6:0]      r_f7_q;
    logic [4:0]      r_rd_q;
    logic            r_ill_q;

    logic            w_valid_d;
    logic [XLEN-1:0] w_rs1_d;
    logic [XLEN-1:0] w_rs2_d;
    logic [2:0]      w_f3_d;
    logic [6:0]      w_f7_d;
    logic [4:0]      w_rd_d;
    logic            w_ill_d;
    logic            w_load;

    assign in_ready = !r_valid_q || out_ready;
    // Flush outranks a same-cycle accept.
    assign w_load   = in_valid && in_ready && !flush;

    always_comb begin
        w_valid_d = r_valid_q;
        w_rs1_d   = r_rs1_q;
        w_rs2_d   = r_rs2_q;
        w_f3_d    = r_f3_q;
        w_f7_d    = r_f7_q;
        w_rd_d    = r_rd_q;
        w_ill_d   = r_ill_q;
        if (flush) begin
            w_valid_d = 1'b0;
        end else if (w_load) begin
            w_valid_d = 1'b1;
        end else if (out_ready) begin
            w_valid_d = 1'b0;
        end
        if (w_load) begin
            w_rs1_d = w_bnd_rs1;
            w_rs2_d = w_bnd_rs2;
            w_f3_d  = w_bnd_f3;
            w_f7_d  = w_bnd_f7;
            w_rd_d  = w_bnd_rd;
            w_ill_d = w_bnd_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_rs1_q   <= '0;
            r_rs2_q   <= '0;
            r_f3_q    <= '0;
            r_f7_q    <= '0;
            r_rd_q    <= '0;
            r_ill_q   <= 1'b0;
        end else begin
            r_valid_q <= w_valid_d;
            r_rs1_q   <= w_rs1_d;
            r_rs2_q   <= w_rs2_d;
            r_f3_q    <= w_f3_d;
            r_f7_q    <= w_f7_d;
            r_rd_q    <= w_rd_d;
            r_ill_q   <= w_ill_d;
        end
    end

    assign out_valid = r_valid_q;
    assign rs1       = r_rs1_q;
    assign rs2       = r_rs2_q;
    assign func3     = r_f3_q;
    assign func7     = r_f7_q;
    assign rd        = r_rd_q;
    assign illegal   = r_ill_q;

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage directly upstream of the 64-bit ALU in the SEQ core.
- Accepts 32-bit RV64I ALU instructions (OP 0x33, OP-IMM 0x13) over a valid/ready handshake.
- Reads a 32x64 register file and produces a registered bundle for the ALU: operand A, operand B, func3, func7 and rd.
- Also hosts the register-file write port used by writeback.

Parameters:
XLEN, 64, datapath and register width
NREGS, 32, architectural register count (x0 hardwired to zero)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instr is valid this cycle
in_ready  output  1  stage can accept instr this cycle
instr  input  32  instruction word
flush  input  1  synchronous kill of the output bundle
wb_en  input  1  register-file write enable
wb_rd  input  5  write address
wb_data  input  XLEN  write data
out_valid  output  1  output bundle valid
out_ready  input  1  ALU side accepts the bundle
rs1  output  XLEN  operand A to ALU
rs2  output  XLEN  operand B to ALU (register value or immediate)
func3  output  3  ALU func3
func7  output  7  ALU func7
rd  output  5  destination register
illegal  output  1  bundle came from an undecodable instruction

Behaviour:
Reset (rst_n low, asynchronous):
- All 32 registers, out_valid, rs1, rs2, func3, func7, rd and illegal go to 0.
- in_ready = 1 once reset is released.
- Reset mid-operation discards any held bundle.

Handshake:
- in_ready = !out_valid || out_ready (combinational; one output register, no skid).
- Accept = in_valid && in_ready. On accept, the bundle is registered and out_valid = 1 at the next edge.
- Latency is 1 cycle instr-to-bundle; throughput is 1 per cycle while out_ready = 1.
- Transfer out = out_valid && out_ready. Transfer without a new accept clears out_valid.
- While out_valid && !out_ready, all outputs hold stable.

Flush:
- Next edge forces out_valid = 0 and blocks any same-cycle accept. Flush has priority over accept.
- Data outputs may hold stale values; they are don't-care when out_valid = 0.

Decode:
- OP (opcode 0x33):
  - rs1 = R[instr[19:15]], rs2 = R[instr[24:20]].
  - func3 = instr[14:12], func7 = instr[31:25].
  - Legal only if func7 = 0x00, or func7 = 0x20 with func3 in {0, 5}.
- OP-IMM (opcode 0x13):
  - rs1 = R[instr[19:15]].
  - func3 = 1 or 5 (shifts): rs2 = zero-extended instr[25:20] (6-bit shamt); func7 = {instr[31:26], 1'b0}. Legal only if instr[31:26] = 0x00 (func3 = 1 or 5), or instr[31:26] = 0x10 (func3 = 5 only).
  - Other func3: rs2 = sign-extended instr[31:20]; func7 forced to 0x00.
- rd = instr[11:7].
- Illegal instruction (any other opcode or failed legality check):
  - Still accepted, with illegal = 1.
  - rs1, rs2, func3, func7 and rd forced to 0.

Register file:
- R[0] reads 0 always; writes with wb_rd = 0 are ignored.
- Write on the rising edge when wb_en = 1.
- Read is combinational with write-bypass: if wb_en && wb_rd != 0 && wb_rd == source index in the accept cycle, the operand takes wb_data.
- The bypass applies to both rs1 and rs2 independently.
- Writes proceed regardless of handshake, stall or flush state.

Arithmetic/width:
- No arithmetic in this block.
- Immediates extend to XLEN exactly as above; no truncation of register values.

Test Plan:
- Reset, then write x5 = 7 and x6 = -9 via wb. ADD x1, x5, x6 (0x006280B3) -> next cycle: out_valid = 1, rs1 = 7, rs2 = -9, func3 = 0, func7 = 0x00, rd = 1, illegal = 0.
- ADDI x2, x5, -16 (0xFF028113) -> rs2 = 0xFFFF_FFFF_FFFF_FFF0, func7 = 0x00. SRAI x3, x5, 33 (0x4212D193) -> rs2 = 33, func3 = 5, func7 = 0x20.
- Back-to-back stream of 3 instructions with out_ready held low from cycle 2:
  - first bundle holds stable and in_ready = 0.
  - on release, bundles emerge in order with no loss or duplication.
- Same-cycle wb_en = 1, wb_rd = 5, wb_data = 0x1234 with SUB x1, x5, x5 -> rs1 = rs2 = 0x1234, func7 = 0x20. wb to x0 followed by a read of x0 -> 0.
- Illegal cases: opcode 0x03 -> illegal = 1 with all data fields 0. OP with func7 = 0x20, func3 = 4 -> illegal = 1.
- flush asserted together with in_valid -> out_valid = 0 next cycle. rst_n pulled low mid-stall -> out_valid = 0 and x5 reads 0 immediately (asynchronous).
